// File: rtl/acc_alu_if.sv
// acc_alu_if: bus bundle between the control side and the acc_alu execution unit.
//   master (control/bench): drives start, opcode, operand, acc_in; observes results
//   slave  (acc_alu)      : observes requests; drives busy, valid_dout, dout, zero, carry
//   start      - request to execute opcode, sampled on rising clk
//   opcode     - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
//   operand    - B operand (shift amount in [3:0] for SHL/SHR)
//   acc_in     - A operand, from the accumulator
//   busy       - MUL in progress, start ignored
//   valid_dout - one-cycle result strobe toward the accumulator
//   dout       - result
//   zero/carry - flags, updated together with valid_dout
interface acc_alu_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] acc_in;
  logic             busy;
  logic             valid_dout;
  logic [WIDTH-1:0] dout;
  logic             zero;
  logic             carry;

  modport master (
    output start, opcode, operand, acc_in,
    input  busy, valid_dout, dout, zero, carry
  );

  modport slave (
    input  start, opcode, operand, acc_in,
    output busy, valid_dout, dout, zero, carry
  );
endinterface

// File: rtl/acc_alu.sv
// acc_alu: accumulator execution unit.
//   clk   - system clock, rising edge
//   reset - synchronous active-low reset (0 = reset)
//   bus   - acc_alu_if slave modport (start/opcode/operand/acc_in in,
//           busy/valid_dout/dout/zero/carry out)
// Logic, add/sub and shift ops complete in one cycle; MUL is a WIDTH-step
// shift-add sequencer that holds busy high while it runs.
module acc_alu #(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      reset,
  acc_alu_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  // Architectural state
  logic [0:0]         state_q,  state_d;
  logic [CW-1:0]      cnt_q,    cnt_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q,   prod_d;
  logic [WIDTH-1:0]   dout_q,   dout_d;
  logic               zero_q,   zero_d;
  logic               carry_q,  carry_d;
  logic               valid_q,  valid_d;

  // Single-cycle datapath results
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic [WIDTH:0]     add_ext;
  logic [WIDTH:0]     sub_ext;
  logic [WIDTH:0]     shl_ext;
  logic [WIDTH:0]     shr_ext;
  logic [3:0]         shamt;

  // MUL step result
  logic [2*WIDTH-1:0] prod_sum;

  assign shamt = bus.operand[3:0];

  // Extended-width forms expose the carry/borrow/shift-out bit directly:
  // bit WIDTH of add/sub is carry/borrow, bit WIDTH of the left shift is
  // A[WIDTH-s], bit 0 of the right shift is A[s-1]; s=0 leaves that bit 0.
  always_comb begin
    add_ext = {1'b0, bus.acc_in} + {1'b0, bus.operand};
    sub_ext = {1'b0, bus.acc_in} - {1'b0, bus.operand};
    shl_ext = {1'b0, bus.acc_in} << shamt;
    shr_ext = {bus.acc_in, 1'b0} >> shamt;
  end

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (bus.opcode)
      OP_ADD: begin
        alu_res   = add_ext[WIDTH-1:0];
        alu_carry = add_ext[WIDTH];
      end
      OP_SUB: begin
        alu_res   = sub_ext[WIDTH-1:0];
        alu_carry = sub_ext[WIDTH];
      end
      OP_AND: alu_res = bus.acc_in & bus.operand;
      OP_OR:  alu_res = bus.acc_in | bus.operand;
      OP_XOR: alu_res = bus.acc_in ^ bus.operand;
      OP_SHL: begin
        alu_res   = shl_ext[WIDTH-1:0];
        alu_carry = shl_ext[WIDTH];
      end
      OP_SHR: begin
        alu_res   = shr_ext[WIDTH:1];
        alu_carry = shr_ext[0];
      end
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  // One shift-add step: accumulate the multiplicand when the current
  // multiplier LSB is set.
  always_comb begin
    prod_sum = prod_q;
    if (mplier_q[0]) begin
      prod_sum = prod_q + mcand_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    dout_d   = dout_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    valid_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.opcode == OP_MUL) begin
            // Operands are captured here, so later acc_in/operand
            // changes cannot disturb the multiply in flight.
            state_d  = S_MUL;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, bus.acc_in};
            mplier_d = bus.operand;
            prod_d   = '0;
          end else begin
            dout_d  = alu_res;
            zero_d  = (alu_res == '0);
            carry_d = alu_carry;
            valid_d = 1'b1;
          end
        end
      end

      S_MUL: begin
        prod_d   = prod_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          dout_d  = prod_sum[WIDTH-1:0];
          zero_d  = (prod_sum[WIDTH-1:0] == '0);
          carry_d = |prod_sum[2*WIDTH-1:WIDTH];
          valid_d = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      dout_q   <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      dout_q   <= dout_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.busy       = (state_q == S_MUL);
  assign bus.valid_dout = valid_q;
  assign bus.dout       = dout_q;
  assign bus.zero       = zero_q;
  assign bus.carry      = carry_q;

endmodule
